// File: rtl/rsa_pkg.sv
// Shared definitions for the modular exponentiation engine.
//   mod_exp_state_t : engine controller states
//   exp_latency(w)  : cycles from an accepted Start to Done for a valid job
package rsa_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMstart,
    StMwait,
    StUpdate,
    StFinish
  } mod_exp_state_t;

  // One MSTART + (W+1) wait + one UPDATE per exponent bit, plus LOAD and FINISH.
  function automatic int unsigned exp_latency(input int unsigned w);
    return w * (w + 3) + 2;
  endfunction

endpackage

// File: rtl/mod_exp_engine_if.sv
// Request/response bundle of the modular exponentiation engine.
//   Start, Base, Exp, Mod      : request, driven by the master
//   Busy, Done, Result, Error  : status/response, driven by the engine (slave)
interface mod_exp_engine_if #(
  parameter int unsigned W = 16
) ();

  logic         Start;
  logic [W-1:0] Base;
  logic [W-1:0] Exp;
  logic [W-1:0] Mod;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;
  logic         Error;

  modport master (
    output Start, Base, Exp, Mod,
    input  Busy, Done, Result, Error
  );

  modport slave (
    input  Start, Base, Exp, Mod,
    output Busy, Done, Result, Error
  );

endinterface

// File: rtl/mod_mult.sv
// Serial interleaved MSB-first modular multiplier: p = a * b mod m.
//   Clk, Reset : clock, synchronous active-high reset
//   start      : latches a, b, m and begins a W-cycle run
//   a, b, m    : operands, a and b must be < m
//   p          : product, valid while done is high and held afterwards
//   done       : single-cycle pulse W+1 cycles after start
module mod_mult #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic [W-1:0] p,
  output logic         done
);

  localparam int unsigned CntW = $clog2(W);

  logic [W-1:0]    a_q, b_q, m_q, p_q, p_d;
  logic [CntW-1:0] idx_q;
  logic            run_q, done_q;
  logic [W+1:0]    acc;

  // 2P + b < 3m when P, b < m, so two conditional subtracts always reduce below m.
  always_comb begin
    acc = {1'b0, p_q, 1'b0} + (a_q[idx_q] ? {2'b00, b_q} : '0);
    if (acc >= {2'b00, m_q}) acc = acc - {2'b00, m_q};
    if (acc >= {2'b00, m_q}) acc = acc - {2'b00, m_q};
    p_d = W'(acc);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      p_q    <= '0;
      idx_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        a_q   <= a;
        b_q   <= b;
        m_q   <= m;
        p_q   <= '0;
        idx_q <= CntW'(W - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        p_q   <= p_d;
        idx_q <= idx_q - CntW'(1);
        if (idx_q == '0) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign p    = p_q;
  assign done = done_q;

endmodule

// File: rtl/mod_exp_engine.sv
// Modular exponentiation engine: Result = Base^Exp mod Mod.
// Right-to-left square-and-multiply; every one of the W exponent bits is processed,
// so latency is fixed and independent of operand values.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : request/response interface (slave side)
module mod_exp_engine
  import rsa_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic Clk,
  input  logic Reset,
  mod_exp_engine_if.slave bus
);

  localparam int unsigned   CntW    = $clog2(W);
  localparam logic [CntW-1:0] LastBit = CntW'(W - 1);

  mod_exp_state_t  state_q, state_d;
  logic [W-1:0]    b_q, b_d, e_q, e_d, m_q, m_d, r_q, r_d;
  logic [W-1:0]    result_q, result_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            error_q, error_d;

  logic            mstart;
  logic [W-1:0]    mul_p, sqr_p;
  logic            mul_done, sqr_done;

  assign mstart = (state_q == StMstart);

  mod_mult #(.W(W)) u_mul (
    .Clk   (Clk),
    .Reset (Reset),
    .start (mstart),
    .a     (r_q),
    .b     (b_q),
    .m     (m_q),
    .p     (mul_p),
    .done  (mul_done)
  );

  mod_mult #(.W(W)) u_sqr (
    .Clk   (Clk),
    .Reset (Reset),
    .start (mstart),
    .a     (b_q),
    .b     (b_q),
    .m     (m_q),
    .p     (sqr_p),
    .done  (sqr_done)
  );

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    e_d      = e_q;
    m_d      = m_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = error_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          b_d     = bus.Base;
          e_d     = bus.Exp;
          m_d     = bus.Mod;
          error_d = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (m_q < W'(2) || b_q >= m_q) begin
          error_d  = 1'b1;
          result_d = '0;
          state_d  = StFinish;
        end else begin
          r_d     = W'(1);
          cnt_d   = '0;
          state_d = StMstart;
        end
      end
      StMstart: state_d = StMwait;
      StMwait: begin
        // Both multipliers start together and have identical latency.
        if (mul_done && sqr_done) state_d = StUpdate;
      end
      StUpdate: begin
        if (e_q[0]) r_d = mul_p;
        b_d   = sqr_p;
        e_d   = e_q >> 1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          result_d = e_q[0] ? mul_p : r_q;
          state_d  = StFinish;
        end else begin
          state_d = StMstart;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      b_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      e_q      <= e_d;
      m_q      <= m_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign bus.Busy   = (state_q != StIdle);
  assign bus.Done   = (state_q == StFinish);
  assign bus.Result = result_q;
  assign bus.Error  = error_q;

endmodule
